// File: rtl/adder_pkg.sv
// Shared types and limits for the accumulating adder pipeline.
package adder_pkg;

  localparam int STAGES_MAX     = 4;
  localparam int OPND_W_MAX     = 32;
  localparam int SUM_W_MAX      = OPND_W_MAX + 1;
  localparam int ACC_W_HEADROOM = 1;

  typedef struct packed {
    logic [SUM_W_MAX-1:0] sum;
    logic                 mode;
    logic                 clr;
  } stage_pl_t;

  // The accumulator must at least hold one full operand sum including its carry.
  function automatic bit acc_w_legal(input int w, input int acc_w);
    return (acc_w >= w + ACC_W_HEADROOM);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One elastic register slice: holds a payload plus a valid bit and accepts
// new data whenever it is empty or its content is being taken downstream.
module adder_pipe_stage #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     up_valid_i,
  input  payload_t up_data_i,
  output logic     up_ready_o,
  output logic     dn_valid_o,
  output payload_t dn_data_o,
  input  logic     dn_ready_i
);

  logic     valid_q, valid_d;
  payload_t data_q, data_d;
  logic     load_s;

  // Handshake and next-state for the slice
  always_comb begin
    up_ready_o = !valid_q || dn_ready_i;
    load_s     = up_valid_i && up_ready_o;
    if (up_ready_o) begin
      valid_d = up_valid_i;
    end else begin
      valid_d = valid_q;
    end
    if (load_s) begin
      data_d = up_data_i;
    end else begin
      data_d = data_q;
    end
  end

  // Slice registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

endmodule

// File: rtl/accum_adder_pipe.sv
// Elastic W-bit adder with STAGES register slices and an optional running
// accumulator. Define ADDER_SAT_EN to saturate the accumulator instead of wrapping.
module accum_adder_pipe
  import adder_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int ACC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam bit ACC_W_OK = acc_w_legal(W, ACC_W);
  localparam int LAST     = STAGES - 1;
  localparam int EXT_W    = ((ACC_W > SUM_W_MAX) ? ACC_W : SUM_W_MAX) + 1;

  if (!ACC_W_OK || STAGES < 1 || STAGES > STAGES_MAX || W > OPND_W_MAX) begin : g_cfg_err
    $error("accum_adder_pipe: illegal W/STAGES/ACC_W combination");
  end

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } result_t;

  logic [W:0]       s_in_s;
  stage_pl_t        in_pl_s;
  logic             chain_valid_s [STAGES];
  stage_pl_t        chain_pl_s    [STAGES];
  logic             chain_ready_s [STAGES];

  stage_pl_t        fin_pl_s;
  logic             fin_load_s;
  logic [ACC_W-1:0] base_s;
  logic [EXT_W-1:0] acc_sum_s;
  logic             carry_s;
  result_t          res_s, res_q_s;
  logic [ACC_W-1:0] acc_q, acc_d;

  assign s_in_s = {1'b0, a_in} + {1'b0, b_in};

  // Beat payload captured by the first slice
  always_comb begin
    in_pl_s      = '0;
    in_pl_s.sum  = SUM_W_MAX'(s_in_s);
    in_pl_s.mode = acc_mode;
    in_pl_s.clr  = acc_clr;
  end

  assign chain_valid_s[0] = in_valid;
  assign chain_pl_s[0]    = in_pl_s;
  assign in_ready         = chain_ready_s[0];

  for (genvar i = 0; i < STAGES - 1; i++) begin : g_mid
    adder_pipe_stage #(.payload_t(stage_pl_t)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (chain_valid_s[i]),
      .up_data_i  (chain_pl_s[i]),
      .up_ready_o (chain_ready_s[i]),
      .dn_valid_o (chain_valid_s[i+1]),
      .dn_data_o  (chain_pl_s[i+1]),
      .dn_ready_i (chain_ready_s[i+1])
    );
  end

  assign fin_pl_s   = chain_pl_s[LAST];
  assign fin_load_s = chain_valid_s[LAST] && chain_ready_s[LAST];

  // Result formed as the beat enters the output slice; the wide add keeps every
  // sum bit in play, anything above ACC_W is the accumulator carry.
  always_comb begin
    if (fin_pl_s.clr) begin
      base_s = {ACC_W{1'b0}};
    end else begin
      base_s = acc_q;
    end
    acc_sum_s = EXT_W'(base_s) + EXT_W'(fin_pl_s.sum);
    carry_s   = |acc_sum_s[EXT_W-1:ACC_W];
    res_s     = '0;
    if (fin_pl_s.mode) begin
`ifdef ADDER_SAT_EN
      if (carry_s) begin
        res_s.sum = {ACC_W{1'b1}};
      end else begin
        res_s.sum = acc_sum_s[ACC_W-1:0];
      end
`else
      res_s.sum = acc_sum_s[ACC_W-1:0];
`endif
      res_s.ovf = carry_s;
    end else begin
      res_s.sum = ACC_W'(fin_pl_s.sum);
      res_s.ovf = 1'b0;
    end
    if (fin_load_s && fin_pl_s.mode) begin
      acc_d = res_s.sum;
    end else begin
      acc_d = acc_q;
    end
  end

  adder_pipe_stage #(.payload_t(result_t)) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .up_valid_i (chain_valid_s[LAST]),
    .up_data_i  (res_s),
    .up_ready_o (chain_ready_s[LAST]),
    .dn_valid_o (out_valid),
    .dn_data_o  (res_q_s),
    .dn_ready_i (out_ready)
  );

  // Running accumulator, advanced only by accumulate beats in acceptance order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = res_q_s.sum;
  assign ovf_o = res_q_s.ovf;

endmodule

// File: tb/tb_accum_adder_pipe.sv
// Bench for accum_adder_pipe: one default instance plus W=16/ACC_W=24 instances
// with STAGES=1 and 4, all fed the same stimulus and scored against a queue model.
module tb_accum_adder_pipe;

  localparam int NDUT = 3;
  localparam int DW   [NDUT] = '{8, 16, 16};
  localparam int DACC [NDUT] = '{16, 24, 24};
  localparam int DST  [NDUT] = '{2, 1, 4};

  typedef struct {
    longint unsigned sum;
    bit              ovf;
    int              cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, acc_mode = 1'b0, acc_clr = 1'b0, out_ready = 1'b1;
  logic [15:0] a_s = 16'h0, b_s = 16'h0;
  logic        in_ready_s [NDUT];
  logic        out_valid_s[NDUT];
  logic        ovf_s      [NDUT];
  logic [15:0] sum0_s;
  logic [23:0] sum1_s, sum2_s;
  longint unsigned sum_v [NDUT];

  exp_t            sb_q [NDUT][$];
  exp_t            log0 [$];
  longint unsigned acc_m [NDUT];
  int              cyc = 0, last_low = -1;
  int              n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  accum_adder_pipe #(.W(8), .STAGES(2), .ACC_W(16)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .a_in(a_s[7:0]), .b_in(b_s[7:0]), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_s[0]), .out_ready(out_ready), .sum_o(sum0_s), .ovf_o(ovf_s[0]));
  accum_adder_pipe #(.W(16), .STAGES(1), .ACC_W(24)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .a_in(a_s), .b_in(b_s), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_s[1]), .out_ready(out_ready), .sum_o(sum1_s), .ovf_o(ovf_s[1]));
  accum_adder_pipe #(.W(16), .STAGES(4), .ACC_W(24)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[2]),
    .a_in(a_s), .b_in(b_s), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_s[2]), .out_ready(out_ready), .sum_o(sum2_s), .ovf_o(ovf_s[2]));

  always_comb begin
    sum_v[0] = 64'(sum0_s);
    sum_v[1] = 64'(sum1_s);
    sum_v[2] = 64'(sum2_s);
  end

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: what the beat accepted now must produce, from the arithmetic rules alone
  task automatic model_push(input int k);
    longint unsigned mw, top, s, t;
    exp_t e;
    mw  = (64'd1 << DW[k]) - 64'd1;
    top = 64'd1 << DACC[k];
    s   = (64'(a_s) & mw) + (64'(b_s) & mw);
    if (acc_mode) begin
      t = (acc_clr ? 64'd0 : acc_m[k]) + s;
      if (t >= top) begin
`ifdef ADDER_SAT_EN
        e.sum = top - 64'd1;
`else
        e.sum = t - top;
`endif
        e.ovf = 1'b1;
      end else begin
        e.sum = t;
        e.ovf = 1'b0;
      end
      acc_m[k] = e.sum;
    end else begin
      e.sum = s;
      e.ovf = 1'b0;
    end
    e.cyc = cyc;
    sb_q[k].push_back(e);
  endtask

  // Scoreboard, sampled mid-cycle while inputs and DUT state are stable
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        sb_q[k].delete();
        acc_m[k] = 64'd0;
      end
    end else begin
      if (!out_ready) last_low = cyc;
      for (int k = 0; k < NDUT; k++) begin
        if (out_valid_s[k] && out_ready) begin
          bit   has;
          exp_t e;
          has = (sb_q[k].size() != 0);
          check_eq($sformatf("d%0d_expected_beat", k), 64'(has), 64'd1);
          if (has) begin
            e = sb_q[k].pop_front();
            check_eq($sformatf("d%0d_sum", k), sum_v[k], e.sum);
            check_eq($sformatf("d%0d_ovf", k), 64'(ovf_s[k]), 64'(e.ovf));
            if (e.cyc > last_low)
              check_eq($sformatf("d%0d_latency", k), 64'(cyc - e.cyc), 64'(DST[k]));
          end
          if (k == 0) begin
            exp_t l;
            l.sum = sum_v[0]; l.ovf = ovf_s[0]; l.cyc = cyc;
            log0.push_back(l);
          end
        end
        if (in_valid && in_ready_s[k]) model_push(k);
      end
    end
    cyc++;
  end

  // Present one beat and hold it until the default instance takes it
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m, input logic c);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; a_s = a; b_s = b; acc_mode = m; acc_clr = c;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready_s[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("send_accepted", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    #1;
    check_eq("rst_out_valid", 64'(out_valid_s[0]), 64'd0);
    check_eq("rst_sum", sum_v[0], 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready_s[0]), 64'd1);
    check_eq("post_rst_ovf", 64'(ovf_s[0]), 64'd0);
    @(posedge clk); #1;

    // Plain add with carry into bit W
    log0.delete();
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();
    check_eq("plain_count", 64'(log0.size()), 64'd1);
    if (log0.size() == 1) begin
      check_eq("plain_sum", log0[0].sum, 64'h0100);
      check_eq("plain_ovf", 64'(log0[0].ovf), 64'd0);
    end

    // Accumulate, back-to-back
    log0.delete();
    send(16'd3, 16'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(16'd3, 16'd4, 1'b1, 1'b0);
    drain();
    check_eq("acc_count", 64'(log0.size()), 64'd4);
    for (int i = 0; i < log0.size(); i++) begin
      check_eq($sformatf("acc_seq%0d", i), log0[i].sum, 64'(7 * (i + 1)));
      if (i > 0) check_eq($sformatf("acc_gap%0d", i), 64'(log0[i].cyc - log0[i-1].cyc), 64'd1);
    end

    // Back-pressure: pipeline fills, results come out in order
    log0.delete();
    n = 0;
    out_ready = 1'b0; in_valid = 1'b1; acc_mode = 1'b0; acc_clr = 1'b0;
    a_s = 16'h0010; b_s = 16'h0020;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready_s[0]) n++;
      @(posedge clk); #1;
      a_s = 16'(16'h0010 + n);
    end
    @(negedge clk);
    check_eq("bp_accepted", 64'(n), 64'd2);
    check_eq("bp_in_ready", 64'(in_ready_s[0]), 64'd0);
    check_eq("bp_hold_valid", 64'(out_valid_s[0]), 64'd1);
    check_eq("bp_hold_sum", sum_v[0], 64'h0030);
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (n < 6) begin
      send(16'(16'h0010 + n), 16'h0020, 1'b0, 1'b0);
      n++;
    end
    drain();
    check_eq("bp_count", 64'(log0.size()), 64'd6);
    for (int i = 0; i < log0.size(); i++)
      check_eq($sformatf("bp_order%0d", i), log0[i].sum, 64'(48 + i));

    // Preload accumulator to 0xFFFE, then push it over the top
    log0.delete();
    send(16'h00FF, 16'h00FF, 1'b1, 1'b1);
    for (int i = 0; i < 127; i++) send(16'h00FF, 16'h00FF, 1'b1, 1'b0);
    send(16'h007F, 16'h007F, 1'b1, 1'b0);
    send(16'h0001, 16'h0001, 1'b1, 1'b0);
    drain();
    check_eq("wrap_count", 64'(log0.size()), 64'd130);
    if (log0.size() == 130) begin
      check_eq("wrap_preload", log0[128].sum, 64'hFFFE);
`ifdef ADDER_SAT_EN
      check_eq("wrap_sum", log0[129].sum, 64'hFFFF);
`else
      check_eq("wrap_sum", log0[129].sum, 64'h0000);
`endif
      check_eq("wrap_ovf", 64'(log0[129].ovf), 64'd1);
    end

    // Asynchronous reset with beats in flight
    send(16'd5, 16'd5, 1'b1, 1'b1);
    send(16'd5, 16'd5, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 64'(out_valid_s[0]), 64'd0);
    check_eq("arst_sum", sum_v[0], 64'd0);
    check_eq("arst_ovf", 64'(ovf_s[0]), 64'd0);
    check_eq("arst_d2_valid", 64'(out_valid_s[2]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("arst_in_ready", 64'(in_ready_s[0]), 64'd1);
    @(posedge clk); #1;
    log0.delete();
    send(16'd2, 16'd2, 1'b1, 1'b0);
    drain();
    check_eq("arst_acc_count", 64'(log0.size()), 64'd1);
    if (log0.size() == 1) check_eq("arst_acc_sum", log0[0].sum, 64'd4);

    // Random traffic: first with random back-pressure, then with none
    for (int c = 0; c < 1200; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a_s       = 16'($urandom);
      b_s       = 16'($urandom);
      acc_mode  = ($urandom_range(0, 2) != 0);
      acc_clr   = ($urandom_range(0, 15) == 0);
      out_ready = (c >= 600) || ($urandom_range(0, 4) != 0);
      @(posedge clk); #1;
    end
    drain();
    for (int k = 0; k < NDUT; k++)
      check_eq($sformatf("d%0d_drained", k), 64'(sb_q[k].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
